// File: rtl/uart_boot_loader.sv
// UART boot loader: watches the received-byte stream for a sync run, then
// loads an address/length-prefixed image into memory over a req/gnt write
// bus while holding the CPU in reset. A run of ON bytes releases the CPU.
//
// state   | meaning
// --------+---------------------------------------------------------------
// HUNT    | idle, counting consecutive STP bytes looking for a sync
// ADDR    | collecting the 4-byte start address, LSB first
// LEN     | collecting the 4-byte byte count, LSB first
// DATA    | packing payload bytes into words and launching writes
// FLUSH   | last byte consumed, waiting for the final write to be granted
// WAIT_ON | image loaded, counting ON bytes (release) or STP bytes (reload)
module uart_boot_loader #(
    parameter logic [7:0]  STP_BYTE = 8'hA5,
    parameter logic [7:0]  ON_BYTE  = 8'h5A,
    parameter int unsigned SYNC_LEN = 33,
    parameter int unsigned ON_LEN   = 33
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] HUNT    = 3'd0;
    localparam logic [2:0] ADDR    = 3'd1;
    localparam logic [2:0] LEN     = 3'd2;
    localparam logic [2:0] DATA    = 3'd3;
    localparam logic [2:0] FLUSH   = 3'd4;
    localparam logic [2:0] WAIT_ON = 3'd5;

    // Terminal values of the run counters (count of bytes already seen).
    localparam logic [7:0] SYNC_LAST = 8'(SYNC_LEN - 1);
    localparam logic [7:0] ON_LAST   = 8'(ON_LEN - 1);

    logic [2:0]  state;
    logic [7:0]  stp_run;
    logic [7:0]  on_run;
    logic [1:0]  byte_idx;
    logic [31:0] addr;
    logic [31:0] cnt;
    logic [31:0] word;

    logic [31:0] word_next;
    logic [3:0]  be_fill;
    logic [7:0]  stp_base;
    logic [7:0]  on_base;

    logic granted;
    logic slot_free;
    logic last_byte;
    logic launch;
    logic is_stp;
    logic is_on;
    logic stp_hit;
    logic on_hit;
    logic wait_byte;

    assign granted   = mem_req && mem_gnt;
    // A new write may be issued when nothing is pending or the pending one
    // completes in this same cycle.
    assign slot_free = !mem_req || mem_gnt;
    assign last_byte = (cnt == 32'd1);
    assign launch    = (state == DATA) && rx_valid && ((byte_idx == 2'd3) || last_byte);
    assign is_stp    = (rx_data == STP_BYTE);
    assign is_on     = (rx_data == ON_BYTE);
    assign stp_hit   = is_stp && (stp_base == SYNC_LAST);
    assign on_hit    = is_on && (on_base == ON_LAST);
    // The byte arriving in the FLUSH cycle that sees the grant belongs to WAIT_ON.
    assign wait_byte = rx_valid && ((state == WAIT_ON) || ((state == FLUSH) && slot_free));
    assign busy      = (state == ADDR) || (state == LEN) || (state == DATA) || (state == FLUSH);
    assign mem_we    = mem_req;

    // Lane merge, byte enables and run-counter bases for the current byte.
    always_comb begin
        word_next = word;
        word_next[{byte_idx, 3'b000} +: 8] = rx_data;
        case (byte_idx)
            2'd0:    be_fill = 4'b0001;
            2'd1:    be_fill = 4'b0011;
            2'd2:    be_fill = 4'b0111;
            default: be_fill = 4'b1111;
        endcase
        // Runs start fresh on the first byte counted after FLUSH.
        stp_base = (state == FLUSH) ? 8'd0 : stp_run;
        on_base  = (state == FLUSH) ? 8'd0 : on_run;
    end

    // Frame FSM, word packing and the single-outstanding write port.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= HUNT;
            stp_run   <= 8'd0;
            on_run    <= 8'd0;
            byte_idx  <= 2'd0;
            addr      <= 32'd0;
            cnt       <= 32'd0;
            word      <= 32'd0;
            mem_req   <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'd0;
            cpu_rst   <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;

            if (granted) begin
                mem_req <= 1'b0;
                addr    <= addr + 32'd4;
            end

            case (state)
                HUNT: begin
                    if (rx_valid) begin
                        if (stp_hit) begin
                            state    <= ADDR;
                            cpu_rst  <= 1'b1;
                            err      <= 1'b0;
                            byte_idx <= 2'd0;
                            stp_run  <= 8'd0;
                            on_run   <= 8'd0;
                        end else if (is_stp) begin
                            stp_run <= stp_run + 8'd1;
                        end else begin
                            stp_run <= 8'd0;
                        end
                    end
                end
                ADDR: begin
                    if (rx_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            addr  <= {rx_data, addr[31:10], 2'b00};
                            state <= LEN;
                        end else begin
                            addr <= {rx_data, addr[31:8]};
                        end
                    end
                end
                LEN: begin
                    if (rx_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        cnt      <= {rx_data, cnt[31:8]};
                        word     <= 32'd0;
                        if (byte_idx == 2'd3) begin
                            if ({rx_data, cnt[31:8]} == 32'd0) begin
                                state   <= WAIT_ON;
                                stp_run <= 8'd0;
                                on_run  <= 8'd0;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (rx_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        cnt      <= cnt - 32'd1;
                        if (launch) begin
                            word <= 32'd0;
                            if (slot_free) begin
                                mem_req   <= 1'b1;
                                mem_addr  <= granted ? (addr + 32'd4) : addr;
                                mem_wdata <= word_next;
                                mem_be    <= be_fill;
                            end else begin
                                // Overrun: drop this word but keep counting.
                                err <= 1'b1;
                            end
                        end else begin
                            word <= word_next;
                        end
                        if (last_byte) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (slot_free) begin
                        state   <= WAIT_ON;
                        stp_run <= 8'd0;
                        on_run  <= 8'd0;
                    end
                end
                WAIT_ON: begin
                end
                default: begin
                    state <= HUNT;
                end
            endcase

            if (wait_byte) begin
                if (on_hit) begin
                    state   <= HUNT;
                    cpu_rst <= 1'b0;
                    done    <= 1'b1;
                    stp_run <= 8'd0;
                    on_run  <= 8'd0;
                end else if (stp_hit) begin
                    state    <= ADDR;
                    err      <= 1'b0;
                    byte_idx <= 2'd0;
                    stp_run  <= 8'd0;
                    on_run   <= 8'd0;
                end else if (is_on) begin
                    on_run  <= on_base + 8'd1;
                    stp_run <= 8'd0;
                end else if (is_stp) begin
                    stp_run <= stp_base + 8'd1;
                    on_run  <= 8'd0;
                end else begin
                    stp_run <= 8'd0;
                    on_run  <= 8'd0;
                end
            end
        end
    end

endmodule
